// File: rtl/test1_av_bridge.sv
// Purpose : valid/ready request stream -> single-cycle method9 ActionValue calls, results queued in a FIFO.
// Latency : result visible on out_* one cycle after the accepting edge (no bypass from method9).
// Backpr. : in_ready drops when the wrapper is not ready, the FIFO is full, or before the first edge after reset.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       request stream (in_ready never looks at in_valid)
//   RDY_method9/EN_method9          wrapper handshake; EN only ever asserted with RDY high
//   method9_in1                     method argument, combinational copy of in_data
//   method9                         method result, sampled when EN_method9 is high
//   out_valid/out_ready/out_data    response stream driven from the registered FIFO head
//   stat_clr/stat_calls/stat_stalls only with TEST1_AV_BRIDGE_STATS_EN defined:
//                                   saturating call and stall counters, stat_clr wins over an event
module test1_av_bridge #(
  parameter int IN_W  = 4,
  parameter int RES_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             RDY_method9,
  output logic             EN_method9,
  output logic [IN_W-1:0]  method9_in1,
  input  logic [RES_W-1:0] method9,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data
`ifdef TEST1_AV_BRIDGE_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_calls,
  output logic [15:0]      stat_stalls
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic             r_live;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [RES_W-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // Full blocks a push even when a pop lands in the same cycle; this keeps
  // in_ready off the out_ready path.
  assign in_ready    = r_live & RDY_method9 & (r_count != C_FULL);
  assign EN_method9  = in_valid & in_ready;
  assign method9_in1 = in_data;
  assign w_push      = EN_method9;
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid & out_ready;
  assign out_data    = r_mem[r_rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // First edge after reset release only arms the bridge.
      r_live <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= method9;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef TEST1_AV_BRIDGE_STATS_EN
  logic        w_stall;
  logic [15:0] r_stat_calls;
  logic [15:0] r_stat_stalls;

  assign w_stall     = in_valid & ~in_ready & r_live;
  assign stat_calls  = r_stat_calls;
  assign stat_stalls = r_stat_stalls;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stat_calls  <= '0;
      r_stat_stalls <= '0;
    end else if (stat_clr) begin
      r_stat_calls  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (EN_method9 && (r_stat_calls != 16'hFFFF)) r_stat_calls  <= r_stat_calls + 16'd1;
      if (w_stall && (r_stat_stalls != 16'hFFFF))   r_stat_stalls <= r_stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_test1_av_bridge.sv
// Bench for test1_av_bridge: directed scenarios followed by a random phase.
// Inputs change 2 time units after the rising edge; checks run on the falling edge.
module tb_test1_av_bridge;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       RDY_method9 = 1'b1;
  logic       EN_method9;
  logic [3:0] method9_in1;
  logic [3:0] method9 = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
`ifdef TEST1_AV_BRIDGE_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_calls;
  logic [15:0] stat_stalls;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: the queue holds the results the bridge should currently
  // be storing, oldest first. live_m mirrors "one edge has passed since reset".
  logic [3:0] sb [$];
  bit         live_m = 1'b0;

  always #5 CLK = ~CLK;

  test1_av_bridge #(.IN_W(4), .RES_W(4), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .RDY_method9 (RDY_method9),
    .EN_method9  (EN_method9),
    .method9_in1 (method9_in1),
    .method9     (method9),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef TEST1_AV_BRIDGE_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_calls  (stat_calls),
    .stat_stalls (stat_stalls)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model check; also records the expected result of every accept.
  always @(negedge CLK) begin
    bit exp_rdy;
    if (!RST_N) begin
      sb.delete();
      live_m = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_en", EN_method9, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
    end else begin
      exp_rdy = live_m && RDY_method9 && (sb.size() != DEPTH);
      chk("in_ready", in_ready, exp_rdy);
      chk("en_method9", EN_method9, in_valid && exp_rdy);
      chk("method9_in1", method9_in1, in_data);
      chk("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) chk("head_data", out_data, sb[0]);
      if (in_valid && exp_rdy) sb.push_back(method9);
      live_m = 1'b1;
    end
  end

  // Response monitor: pops the scoreboard on every output handshake.
  always @(negedge CLK) begin
    #1;
    if (RST_N && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected actual=%0h required=none", out_data);
      end else begin
        chk("resp_data", out_data, sb[0]);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Present one request and hold it until the bridge takes it.
  task automatic send(input logic [3:0] d, input logic [3:0] r);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    method9  = r;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge CLK);
      #2;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
    end
  endtask

  initial begin
    // Reset release with a request already waiting: single call 5 -> A.
    in_data = 4'h5;
    method9 = 4'hA;
    idle(3);
    RST_N = 1'b1;
    send(4'h5, 4'hA);
    idle(3);

    // Back-pressure: four fill the FIFO, the fifth waits for a pop.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(4'(k), 4'(k));
    in_valid = 1'b1;
    in_data  = 4'h5;
    method9  = 4'h5;
    idle(3);
    out_ready = 1'b1;
    send(4'h5, 4'h5);
    idle(6);

    // Wrap: ten back-to-back calls with the output draining.
    for (int k = 0; k < 10; k++) send(4'(k), 4'(k));
    idle(4);

    // Method not ready for three cycles.
`ifdef TEST1_AV_BRIDGE_STATS_EN
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
`endif
    RDY_method9 = 1'b0;
    in_valid    = 1'b1;
    idle(3);
    in_valid    = 1'b0;
    RDY_method9 = 1'b1;
`ifdef TEST1_AV_BRIDGE_STATS_EN
    chk("stat_stalls", stat_stalls, 3);
`endif
    idle(2);

    // Mid-run reset with three entries queued and a request in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(4'(k + 7), 4'(k + 7));
    in_valid = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_en", EN_method9, 0);
    idle(2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    RST_N = 1'b1;
    idle(3);

    // Random phase with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 4'($urandom);
      method9     = 4'($urandom);
      RDY_method9 = ($urandom_range(0, 7) != 0);
      out_ready   = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 399) == 0) begin
        RST_N = 1'b0;
        idle(2);
        RST_N = 1'b1;
      end
      idle(1);
    end

    // Drain whatever is left.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(DEPTH + 3);
    chk("drain_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
